// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// default latencies and the hazard-unit helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic is_md_busy_op(input logic [2:0] op);
        logic busy_op;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: busy_op = 1'b1;
            default:                            busy_op = 1'b0;
        endcase
        return busy_op;
    endfunction

endpackage

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, launches MULT/DIV with a fixed
// latency, and services MTHI/MTLO directly while idle.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Op,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             div_zero_q;

    logic launch;
    logic finish;
    logic do_mthi;
    logic do_mtlo;
    logic is_div;
    logic is_mult;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               b_zero;
    logic               div_ovf;
    logic [31:0]        div_b;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // The divider never sees zero or the INT_MIN/-1 overflow pair; both are
    // resolved by the selection logic below, so a harmless divisor of 1 is used.
    assign b_zero  = (B == 32'd0);
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign div_b   = (b_zero || div_ovf) ? 32'd1 : B;

    assign quot_s = $signed(A) / $signed(div_b);
    assign rem_s  = $signed(A) % $signed(div_b);
    assign quot_u = A / div_b;
    assign rem_u  = A % div_b;

    assign is_mult = (Op == MD_MULT) || (Op == MD_MULTU);
    assign is_div  = (Op == MD_DIV)  || (Op == MD_DIVU);

    assign Busy = (state_q == ST_BUSY);

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        finish  = 1'b0;
        do_mthi = 1'b0;
        do_mtlo = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (is_md_busy_op(Op)) begin
                        launch  = 1'b1;
                        state_d = ST_BUSY;
                    end
                    do_mthi = (Op == MD_MTHI);
                    do_mtlo = (Op == MD_MTLO);
                end
            end
            ST_BUSY: begin
                if (count_q == CNT_W'(1)) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Results are captured at launch and only copied to HI/LO on completion,
    // so an async reset mid-operation discards them cleanly.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            div_zero_q <= 1'b0;
            HI         <= '0;
            LO         <= '0;
        end else begin
            if (launch) begin
                case (Op)
                    MD_MULT:  {r_hi, r_lo} <= prod_s;
                    MD_MULTU: {r_hi, r_lo} <= prod_u;
                    MD_DIV:   {r_hi, r_lo} <= div_ovf ? {32'd0, 32'h8000_0000} : {rem_s, quot_s};
                    MD_DIVU:  {r_hi, r_lo} <= {rem_u, quot_u};
                    default:  {r_hi, r_lo} <= {r_hi, r_lo};
                endcase
                div_zero_q <= is_div && b_zero;
                count_q    <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (state_q == ST_BUSY) begin
                count_q <= count_q - 1'b1;
            end

            if (finish && !div_zero_q) begin
                HI <= r_hi;
                LO <= r_lo;
            end
            if (do_mthi) begin
                HI <= A;
            end
            if (do_mtlo) begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: table of operations with a scoreboard of
// expected HI/LO/latency, plus hand-written busy-injection and reset sequences.
module tb_mdu;
    import mdu_pkg::*;

    logic        Clk;
    logic        Reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  Op;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[13];
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] cur_hi = 32'd0;
    logic [31:0] cur_lo = 32'd0;

    mdu dut (
        .Clk   (Clk),
        .Reset (Reset),
        .A     (A),
        .B     (B),
        .Op    (Op),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one launch at a negedge, queue its expectation, and drop Start after the edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ehi, input logic [31:0] elo,
                                 input int ecyc, input string name);
        exp_t e;
        @(negedge Clk);
        Op    = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        e.hi = ehi; e.lo = elo; e.cycles = ecyc; e.name = name;
        sb.push_back(e);
        #1;
        checkOutput({name, "_busy_pre_edge"}, {31'd0, Busy}, 32'd0);
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Op    = MD_NONE;
    endtask

    // Count Busy cycles, verify HI/LO hold meanwhile, then pop and compare the result.
    task automatic waitDone(input bit inject);
        exp_t e;
        int   cycles;
        @(negedge Clk);
        e = sb.pop_front();
        cycles = 0;
        while (Busy && cycles < 64) begin
            checkOutput({e.name, "_hold_hi"}, HI, cur_hi);
            checkOutput({e.name, "_hold_lo"}, LO, cur_lo);
            cycles++;
            if (inject) begin
                case (cycles)
                    2: begin Op = MD_MTLO; A = 32'hDEAD_BEEF; Start = 1'b1; end
                    3: begin Op = MD_MULT; A = 32'd9; B = 32'd9; Start = 1'b1; end
                    4: begin Op = MD_NONE; Start = 1'b0; end
                    default: ;
                endcase
            end
            @(negedge Clk);
        end
        if (cycles >= 64) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: Busy still high after %0d cycles, expected low", e.name, cycles);
        end
        checkOutput({e.name, "_cycles"}, 32'(cycles), 32'(e.cycles));
        checkOutput({e.name, "_hi"}, HI, e.hi);
        checkOutput({e.name, "_lo"}, LO, e.lo);
        cur_hi = e.hi;
        cur_lo = e.lo;
    endtask

    initial begin
        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5,  "mult_neg"};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 5,  "multu"};
        vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg"};
        vecs[3]  = '{MD_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 10, "divu"};
        vecs[4]  = '{MD_MTHI,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h0000_0003, 0,  "mthi"};
        vecs[5]  = '{MD_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h1234_5678, 32'h0000_0003, 10, "divu_by0"};
        vecs[6]  = '{MD_MTLO,  32'hCAFE_F00D, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D, 0,  "mtlo"};
        vecs[7]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, "div_ovf"};
        vecs[8]  = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, "div_posneg"};
        vecs[9]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5,  "mult_min"};
        vecs[10] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5,  "multu_max"};
        vecs[11] = '{MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 10, "div_negneg"};
        vecs[12] = '{MD_NONE,  32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 32'h0000_0003, 0,  "none"};

        Reset = 1'b1;
        Start = 1'b0;
        Op    = MD_NONE;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(negedge Clk);
        checkOutput("reset_busy", {31'd0, Busy}, 32'd0);
        checkOutput("reset_hi", HI, 32'd0);
        checkOutput("reset_lo", LO, 32'd0);
        Reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                          vecs[i].cycles, vecs[i].name);
            waitDone(1'b0);
        end

        // Launches arriving while busy must be ignored completely.
        applyStimulus(MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 5, "mult_inject");
        waitDone(1'b1);

        // Async reset in the middle of a divide discards the pending result.
        @(negedge Clk);
        Op = MD_DIV; A = 32'd100; B = 32'd7; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Op    = MD_NONE;
        repeat (4) @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("async_rst_busy", {31'd0, Busy}, 32'd0);
        checkOutput("async_rst_hi", HI, 32'd0);
        checkOutput("async_rst_lo", LO, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (12) @(negedge Clk);
        checkOutput("post_rst_busy", {31'd0, Busy}, 32'd0);
        checkOutput("post_rst_hi", HI, 32'd0);
        checkOutput("post_rst_lo", LO, 32'd0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        applyStimulus(MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5, "mult_after_rst");
        waitDone(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the EX stage of the pipelined MIPS core.
- Consumes the two source operands read from the register file, after forwarding muxes, and executes MULT/MULTU/DIV/DIVU as multi-cycle operations.
- Owns the HI/LO registers, services MTHI/MTLO, and supplies HI/LO to the EX result mux for MFHI/MFLO.
- Its Busy output drives the hazard unit's ID-stage stall for any MD-class instruction.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU.
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- A  in  32  rs operand, forwarded.
- B  in  32  rt operand, forwarded.
- Op  in  3  operation code: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- Start  in  1  one-cycle launch qualifier for Op. The EX controller deasserts it when the instruction is flushed or an interrupt is taken.
- Busy  out  1  an operation is in flight.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

Behaviour:
- Reset (async, any time, including mid-operation):
  - Busy=0, HI=0, LO=0, counter=0.
  - Any pending result is discarded.
  - Outputs are valid immediately on assertion; no clock is needed.
- Idle state (Busy=0), at a rising Clk with Start=1:
  - MULT/MULTU: compute the 64-bit product of A,B (signed for MULT, unsigned for MULTU) into internal rHI/rLO. Set Busy=1 and counter=MULT_CYCLES.
  - DIV/DIVU: compute quotient into rLO and remainder into rHI (signed for DIV, unsigned for DIVU). Set Busy=1 and counter=DIV_CYCLES.
  - Signed DIV: quotient truncates toward zero; remainder takes the sign of the dividend. 0x80000000/-1 gives LO=0x80000000, HI=0.
  - DIV/DIVU with B==0: still goes Busy for DIV_CYCLES; at completion HI/LO are left unchanged.
  - MTHI: HI<=A at that edge. MTLO: LO<=A. Busy stays 0.
  - MD_NONE, or Start=0: no effect.
- Busy state:
  - The counter decrements every cycle.
  - On the edge where the counter goes 1->0: HI<=rHI, LO<=rLO (unless divide-by-zero), Busy<=0.
  - Busy is therefore high for exactly N cycles starting the cycle after the Start edge.
  - HI/LO keep their old values throughout Busy.
  - Start during Busy is ignored entirely (no restart, no MTHI/MTLO). The hazard unit guarantees this does not occur, but the block must still be safe.
- Busy is registered, with no combinational path from Start. The hazard unit stalls on (Start & Op is mul/div) | Busy.
- HI/LO outputs come straight from the registers. MFHI/MFLO issued the cycle after completion sees the new values.
- Only a single FSM exists (IDLE, BUSY); the counter width is derived from max(MULT_CYCLES, DIV_CYCLES).

Decomposition:
- Package mdu_pkg:
  - Op encodings (MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6).
  - Default cycle-count constants.
  - is_md_busy_op() helper for the hazard unit.
- No sub-module. Arithmetic is behavioural (*, /, %) with explicit $signed casts, captured into the result registers.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE B=0x00000003, Start 1 cycle -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with the same operands -> after 5 cycles HI=0x00000002, LO=0xFFFFFFFA. HI/LO read the previous values during every Busy cycle.
- DIV A=0xFFFFFFF9 (-7) B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7 B=2 -> LO=3, HI=1.
- MTHI A=0x12345678, then DIVU A=5 B=0 -> Busy 10 cycles; HI stays 0x12345678 and LO unchanged after completion.
- Start MULT, then at Busy cycle 2 pulse MTLO A=0xDEADBEEF and another MULT -> both ignored; the original product lands at cycle 5; Busy falls after exactly 5 cycles.
- Start DIV, assert Reset asynchronously mid-cycle at Busy cycle 4 -> Busy, HI and LO read 0 before the next Clk edge; no late writeback; a fresh MULT 3*4 afterwards gives LO=12, HI=0.
